// File: rtl/snn_cfg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_cfg_pkg: shared states, opcodes and region lengths for snn_cfg_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package snn_cfg_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_GETT = 2'd2,
        S_RUN  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        R_W = 2'd0,
        R_D = 2'd1,
        R_P = 2'd2
    } region_e;

    localparam logic [7:0] OP_W   = 8'h01;
    localparam logic [7:0] OP_D   = 8'h02;
    localparam logic [7:0] OP_P   = 8'h03;
    localparam logic [7:0] OP_RUN = 8'h04;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DELAY_BYTES = 16'd104;

    function automatic logic [CNT_W-1:0] weight_bytes(input int nbits);
        return CNT_W'(26 * nbits);
    endfunction

    function automatic logic [CNT_W-1:0] param_bytes(input int nbits);
        return CNT_W'((3 * nbits + 7) / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_step_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_step_timer: step/cycle counters that pace a run of T timesteps
// Rev 1.0
// ----------------------------------------------------------------------------
module snn_step_timer
    import snn_cfg_pkg::*;
#(
    parameter int STEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] T,
    output logic       enable,
    output logic       delay_tick,
    output logic       step_start,
    output logic       last
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(STEP_CYCLES - 1);

    logic          en_q, en_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] c_q, c_d;
    logic [7:0]    s_q, s_d;
    logic [7:0]    t_q, t_d;
    logic          wrap;

    assign wrap       = en_q && (c_q == C_LAST);
    assign last       = wrap && (s_q == t_q - 8'd1);
    // step_start marks the edge that enters c=0 of a step
    assign step_start = start || (wrap && !last);
    assign enable     = en_q;
    assign delay_tick = tick_q;

    always_comb begin
        en_d = en_q;
        c_d  = c_q;
        s_d  = s_q;
        t_d  = t_q;
        if (start) begin
            en_d = 1'b1;
            c_d  = '0;
            s_d  = '0;
            t_d  = T;
        end else if (en_q) begin
            if (wrap) begin
                c_d = '0;
                if (last) begin
                    en_d = 1'b0;
                end else begin
                    s_d = s_q + 8'd1;
                end
            end else begin
                c_d = c_q + 1'b1;
            end
        end
        tick_d = en_d && (c_d == C_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q   <= 1'b0;
            tick_q <= 1'b0;
            c_q    <= '0;
            s_q    <= '0;
            t_q    <= '0;
        end else begin
            en_q   <= en_d;
            tick_q <= tick_d;
            c_q    <= c_d;
            s_q    <= s_d;
            t_q    <= t_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_cfg_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_cfg_scheduler: byte-stream config loader and timestep sequencer for the SNN core
// Rev 1.0
// ----------------------------------------------------------------------------
module snn_cfg_scheduler
    import snn_cfg_pkg::*;
#(
    parameter int Nbits       = 4,
    parameter int STEP_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [23:0]          spike_in,
    input  logic [1:0]           core_spikes,
    output logic [23:0]          input_spikes,
    output logic [208*Nbits-1:0] weights,
    output logic [831:0]         delays,
    output logic [Nbits-1:0]     threshold,
    output logic [Nbits-1:0]     decay,
    output logic [Nbits-1:0]     refractory_period,
    output logic                 enable,
    output logic                 delay_tick,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           spike_cnt0,
    output logic [7:0]           spike_cnt1
);

    localparam logic [CNT_W-1:0] W_LEN = weight_bytes(Nbits);
    localparam logic [CNT_W-1:0] P_LEN = param_bytes(Nbits);
    localparam int PW   = 3 * Nbits;
    localparam int W_IW = $clog2(208 * Nbits);
    localparam int D_IW = $clog2(832);

    state_e               state_q, state_d;
    region_e              region_q, region_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, region_len;
    logic                 ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic                 xfer, byte_last, run_start;
    logic [208*Nbits-1:0] weights_q;
    logic [831:0]         delays_q;
    logic [PW-1:0]        params_q, params_d;
    logic [23:0]          in_spk_q;
    logic [7:0]           cnt0_q, cnt1_q;
    logic [W_IW-1:0]      w_idx;
    logic [D_IW-1:0]      d_idx;
    logic                 t_enable, t_tick, t_step_start, t_last;

    assign xfer      = cfg_valid && ready_q;
    assign byte_last = (cnt_q == region_len - 1'b1);
    assign w_idx     = W_IW'({cnt_q, 3'b000});
    assign d_idx     = D_IW'({cnt_q, 3'b000});

    always_comb begin
        case (region_q)
            R_W:     region_len = W_LEN;
            R_D:     region_len = DELAY_BYTES;
            default: region_len = P_LEN;
        endcase
    end

    snn_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (run_start),
        .T          (cfg_data),
        .enable     (t_enable),
        .delay_tick (t_tick),
        .step_start (t_step_start),
        .last       (t_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    case (cfg_data)
                        OP_W:    begin state_d = S_LOAD; region_d = R_W; end
                        OP_D:    begin state_d = S_LOAD; region_d = R_D; end
                        OP_P:    begin state_d = S_LOAD; region_d = R_P; end
                        OP_RUN:  state_d = S_GETT;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  if (xfer && byte_last) state_d = S_IDLE;
            S_GETT:  if (xfer) state_d = (cfg_data == 8'd0) ? S_IDLE : S_RUN;
            S_RUN:   if (t_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d   = (state_d != S_RUN);
        run_start = (state_q == S_GETT) && xfer && (cfg_data != 8'd0);
        done_d    = ((state_q == S_GETT) && xfer && (cfg_data == 8'd0)) || t_last;
        err_d     = (state_q == S_IDLE) && xfer &&
                    !(cfg_data inside {OP_W, OP_D, OP_P, OP_RUN});
        cnt_d     = '0;
        if (state_q == S_LOAD) begin
            cnt_d = xfer ? (byte_last ? '0 : cnt_q + 1'b1) : cnt_q;
        end
    end

    // Parameter bytes map bit-by-bit so padding beyond 3*Nbits is dropped
    always_comb begin
        params_d = params_q;
        for (int i = 0; i < PW; i++) begin
            if ((i / 8) == int'(cnt_q)) params_d[i] = cfg_data[3'(i % 8)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region_q <= R_W;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            region_q <= region_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weights_q <= '0;
            delays_q  <= '0;
            params_q  <= '0;
        end else if ((state_q == S_LOAD) && xfer) begin
            case (region_q)
                R_W:     weights_q[w_idx +: 8] <= cfg_data;
                R_D:     delays_q[d_idx +: 8]  <= cfg_data;
                default: params_q <= params_d;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_spk_q <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            if (t_last) begin
                in_spk_q <= '0;
            end else if (t_step_start) begin
                in_spk_q <= spike_in;
            end
            if (run_start) begin
                cnt0_q <= '0;
                cnt1_q <= '0;
            end else if (t_enable) begin
                if (core_spikes[0] && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
                if (core_spikes[1] && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign cfg_ready         = ready_q;
    assign input_spikes      = in_spk_q;
    assign weights           = weights_q;
    assign delays            = delays_q;
    assign threshold         = params_q[Nbits-1:0];
    assign decay             = params_q[2*Nbits-1:Nbits];
    assign refractory_period = params_q[3*Nbits-1:2*Nbits];
    assign enable            = t_enable;
    assign delay_tick        = t_tick;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign err               = err_q;
    assign spike_cnt0        = cnt0_q;
    assign spike_cnt1        = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_cfg_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_snn_cfg_scheduler: directed + randomized bench with a byte-array bank model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_snn_cfg_scheduler;
    import snn_cfg_pkg::*;

    localparam int NB = 4;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [23:0]   spike_in;
    logic [1:0]    core_spikes;
    logic [23:0]   input_spikes;
    logic [831:0]  weights;
    logic [831:0]  delays;
    logic [NB-1:0] threshold, decay, refractory_period;
    logic          enable, delay_tick, busy, done, err;
    logic [7:0]    spike_cnt0, spike_cnt1;

    int n_tests;
    int n_fail;

    logic [7:0] w_m [104];
    logic [7:0] d_m [104];

    always #5 clk = ~clk;

    snn_cfg_scheduler #(
        .Nbits       (NB),
        .STEP_CYCLES (SC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_data          (cfg_data),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .spike_in          (spike_in),
        .core_spikes       (core_spikes),
        .input_spikes      (input_spikes),
        .weights           (weights),
        .delays            (delays),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .enable            (enable),
        .delay_tick        (delay_tick),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .spike_cnt0        (spike_cnt0),
        .spike_cnt1        (spike_cnt1)
    );

    function automatic logic [831:0] pack(input logic [7:0] m [104]);
        logic [831:0] r;
        r = '0;
        for (int i = 0; i < 104; i++) r[8*i +: 8] = m[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [831:0] obs, input logic [831:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        cfg_data  = b;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        chk("send_ready", cfg_ready, 1'b1);
        cyc();
        cfg_valid = 1'b0;
    endtask

    // One run of T steps; the expected schedule is T*SC enabled cycles starting
    // the cycle after T is accepted, with spike_in sampled on each step boundary.
    task automatic do_run(input int T, input bit fixed_in, input int cs_mode, input bit hold_valid);
        int          e0, e1;
        logic [23:0] exp_in, nxt;
        logic [1:0]  cs;
        send(OP_RUN);
        chk("run_op_err", err, 1'b0);
        chk("gett_busy", busy, 1'b1);
        exp_in   = fixed_in ? 24'hABCDEF : 24'($urandom);
        spike_in = exp_in;
        send(8'(T));
        e0 = 0;
        e1 = 0;
        if (hold_valid) begin
            cfg_valid = 1'b1;
            cfg_data  = OP_W;
        end
        for (int idx = 0; idx < T * SC; idx++) begin
            chk("run_enable", enable, 1'b1);
            chk("run_tick", delay_tick, (idx % SC) == SC - 1);
            chk("run_in_spk", input_spikes, exp_in);
            chk("run_ready", cfg_ready, 1'b0);
            chk("run_busy", busy, 1'b1);
            chk("run_done", done, 1'b0);
            cs = (cs_mode == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            core_spikes = cs;
            e0 += int'(cs[0]);
            e1 += int'(cs[1]);
            if (!fixed_in) begin
                nxt      = 24'($urandom);
                spike_in = nxt;
                if ((idx % SC) == SC - 1) exp_in = nxt;
            end
            cyc();
        end
        chk("end_done", done, 1'b1);
        chk("end_enable", enable, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_in_spk", input_spikes, 24'd0);
        chk("end_ready", cfg_ready, 1'b1);
        chk("end_cnt0", spike_cnt0, (e0 > 255) ? 255 : e0);
        chk("end_cnt1", spike_cnt1, (e1 > 255) ? 255 : e1);
        cfg_valid   = 1'b0;
        core_spikes = 2'b11;
        cyc();
        chk("post_done", done, 1'b0);
        chk("post_enable", enable, 1'b0);
        chk("post_cnt0", spike_cnt0, (e0 > 255) ? 255 : e0);
        chk("post_cnt1", spike_cnt1, (e1 > 255) ? 255 : e1);
        core_spikes = 2'b00;
        if (hold_valid) chk("hold_no_consume", weights, pack(w_m));
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_data    = 8'd0;
        spike_in    = 24'd0;
        core_spikes = 2'b00;
        for (int i = 0; i < 104; i++) begin
            w_m[i] = 8'd0;
            d_m[i] = 8'd0;
        end

        // Reset state
        cyc();
        cyc();
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", enable, 1'b0);
        chk("rst_weights", weights, '0);
        chk("rst_delays", delays, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt0", spike_cnt0, 8'd0);
        reset = 1'b0;
        chk("rst_release_ready", cfg_ready, 1'b0);
        cyc();
        chk("ready_after_rst", cfg_ready, 1'b1);

        // Weight load with an incrementing pattern
        send(OP_W);
        for (int k = 0; k < 104; k++) begin
            w_m[k] = 8'(k);
            send(8'(k));
            chk("w_byte", weights[8*k +: 8], 8'(k));
        end
        chk("w_lo", weights[7:0], 8'h00);
        chk("w_b1", weights[15:8], 8'h01);
        chk("w_hi", weights[831:824], 8'h67);
        chk("w_all", weights, pack(w_m));
        chk("w_idle", busy, 1'b0);
        chk("w_delays_untouched", delays, '0);

        // Params load
        send(OP_P);
        send(8'h5A);
        send(8'h03);
        chk("p_thr", threshold, 4'hA);
        chk("p_decay", decay, 4'h5);
        chk("p_refr", refractory_period, 4'h3);

        // Random delay load
        send(OP_D);
        for (int k = 0; k < 104; k++) begin
            d_m[k] = 8'($urandom);
            send(d_m[k]);
        end
        chk("d_all", delays, pack(d_m));
        chk("d_weights_hold", weights, pack(w_m));

        // Runs
        do_run(3, 1'b1, 0, 1'b0);
        do_run(40, 1'b0, 1, 1'b0);

        // T=0 leaves counters alone and never enables
        send(OP_RUN);
        send(8'd0);
        chk("t0_done", done, 1'b1);
        chk("t0_enable", enable, 1'b0);
        chk("t0_busy", busy, 1'b0);
        chk("t0_cnt0", spike_cnt0, 8'd255);
        cyc();
        chk("t0_done_clr", done, 1'b0);
        chk("t0_enable2", enable, 1'b0);

        // Illegal opcode
        send(8'h7F);
        chk("bad_err", err, 1'b1);
        chk("bad_busy", busy, 1'b0);
        cyc();
        chk("bad_err_clr", err, 1'b0);

        do_run(2, 1'b0, 0, 1'b1);
        repeat (3) do_run(int'($urandom_range(1, 6)), 1'b0, 0, 1'b0);
        chk("hold_weights", weights, pack(w_m));
        chk("hold_delays", delays, pack(d_m));
        chk("hold_thr", threshold, 4'hA);

        // Reset partway through a delay load
        send(OP_D);
        for (int k = 0; k < 50; k++) send(8'($urandom));
        reset = 1'b1;
        #2;
        chk("mid_load_delays", delays, '0);
        chk("mid_load_weights", weights, '0);
        chk("mid_load_busy", busy, 1'b0);
        chk("mid_load_ready", cfg_ready, 1'b0);
        chk("mid_load_thr", threshold, 4'h0);
        for (int i = 0; i < 104; i++) begin
            w_m[i] = 8'd0;
            d_m[i] = 8'd0;
        end
        cyc();
        reset = 1'b0;
        cyc();
        chk("mid_load_ready2", cfg_ready, 1'b1);
        send(8'h7F);
        chk("mid_load_idle_err", err, 1'b1);

        // Reset partway through a run
        send(OP_RUN);
        send(8'd5);
        core_spikes = 2'b11;
        repeat (13) cyc();
        reset = 1'b1;
        #2;
        chk("mid_run_enable", enable, 1'b0);
        chk("mid_run_cnt0", spike_cnt0, 8'd0);
        chk("mid_run_cnt1", spike_cnt1, 8'd0);
        chk("mid_run_busy", busy, 1'b0);
        chk("mid_run_done", done, 1'b0);
        chk("mid_run_tick", delay_tick, 1'b0);
        chk("mid_run_in_spk", input_spikes, 24'd0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("after_rst_done", done, 1'b0);
            chk("after_rst_enable", enable, 1'b0);
        end
        core_spikes = 2'b00;
        chk("after_rst_cnt0", spike_cnt0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
